// File: rtl/noc_flit_pkg.sv
// Flit layout, field helpers and FSM state type shared by the NoC injection logic.
// The layout is fixed network-wide, so it lives here rather than in module parameters.
package noc_flit_pkg;

  // Network-wide flit geometry
  localparam int WIDTH  = 128;
  localparam int N      = 16;
  localparam int NUM_VC = 2;

  // Address widths
  localparam int DEST_W = $clog2(N);
  localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  // Field positions (LSB of each field); control bits sit at the top
  localparam int VALID_POS = WIDTH - 1;
  localparam int HEAD_POS  = WIDTH - 2;
  localparam int TAIL_POS  = WIDTH - 3;
  localparam int VC_POS    = TAIL_POS - VC_W;
  localparam int DEST_POS  = VC_POS - DEST_W;
  localparam int DATA_POS  = 0;
  localparam int DATA_W    = DEST_POS;

  typedef logic [WIDTH-1:0] flit_t;
  typedef logic [VC_W-1:0]  vc_t;

  // Wormhole lock state of the injection port
  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  function automatic vc_t flit_vc(input flit_t f);
    return f[VC_POS +: VC_W];
  endfunction

  function automatic logic flit_is_head(input flit_t f);
    return f[HEAD_POS];
  endfunction

  function automatic logic flit_is_tail(input flit_t f);
    return f[TAIL_POS];
  endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin pick: the first set request found when scanning
// upward from ptr+1 (wrapping) wins. Output is one-hot or all zeros.
module noc_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant
);

  // Scan all positions starting just after the last winner
  always_comb begin
    logic found;
    int   idx;
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Shares one router injection port among NUM_REQ requesters: round-robin
// arbitration, wormhole packet locking, per-VC credit flow control and a
// registered flit output.
module noc_inject_arbiter
  import noc_flit_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int VC_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] req_flit,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [WIDTH-1:0]              flit_out,
  input  logic [NUM_VC-1:0]             credits_in,
  output logic                          credit_err
);

  localparam int REQ_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(VC_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(VC_DEPTH);
  localparam logic [REQ_W-1:0] LAST_REQ = REQ_W'(NUM_REQ - 1);

  state_t             state, state_next;
  logic [REQ_W-1:0]   owner, last_grant;
  logic [CNT_W-1:0]   credit_cnt [NUM_VC];
  logic [NUM_REQ-1:0] eligible, arb_grant;
  logic               grant_any;
  logic [REQ_W-1:0]   grant_idx;
  flit_t              grant_flit;
  logic [NUM_VC-1:0]  send_vc, at_full;

  // Eligibility: valid, credit available on the flit's VC now, and owner-only while locked
  always_comb begin
    eligible = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      eligible[r] = req_valid[r]
                 && (credit_cnt[flit_vc(req_flit[r])] != '0)
                 && ((state == IDLE) || (owner == REQ_W'(r)));
    end
  end

  noc_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req   (eligible),
    .ptr   (last_grant),
    .grant (arb_grant)
  );

  // FSM state register; a reset mid-packet simply drops the lock
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state: lock on a multi-flit head, unlock on the tail
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any && flit_is_head(grant_flit) && !flit_is_tail(grant_flit))
                 state_next = LOCKED;
      LOCKED:  if (grant_any && flit_is_tail(grant_flit))
                 state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: grant is suppressed while reset is held; decode winner index and flit
  always_comb begin
    req_ready = reset ? arb_grant : '0;
    grant_any = |req_ready;
    grant_idx = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (req_ready[r]) grant_idx = REQ_W'(r);
    end
    grant_flit = req_flit[grant_idx];
  end

  // Round-robin pointer and packet owner
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= LAST_REQ;
      owner      <= '0;
    end else if (grant_any) begin
      last_grant <= grant_idx;
      if (state == IDLE && state_next == LOCKED) owner <= grant_idx;
    end
  end

  // Per-VC send and overflow detection
  always_comb begin
    send_vc = '0;
    at_full = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      send_vc[v] = grant_any && (flit_vc(grant_flit) == VC_W'(v));
      at_full[v] = (credit_cnt[v] == CNT_FULL);
    end
  end

  // Credit counters: send decrements, return increments, both cancel; saturate at VC_DEPTH
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (!reset) begin
        credit_cnt[v] <= CNT_FULL;
      end else if (credits_in[v] && !send_vc[v]) begin
        if (!at_full[v]) credit_cnt[v] <= credit_cnt[v] + 1'b1;
      end else if (send_vc[v] && !credits_in[v]) begin
        credit_cnt[v] <= credit_cnt[v] - 1'b1;
      end
    end
  end

  // Sticky error: any credit returned to a VC whose counter is already full
  always_ff @(posedge clk) begin
    if (!reset) credit_err <= 1'b0;
    else        credit_err <= credit_err | (|(credits_in & at_full));
  end

  // Output register: granted flit with valid forced high, otherwise all zeros
  always_ff @(posedge clk) begin
    if (!reset) begin
      flit_out <= '0;
    end else if (grant_any) begin
      flit_out            <= grant_flit;
      flit_out[VALID_POS] <= 1'b1;
    end else begin
      flit_out <= '0;
    end
  end

endmodule

// File: doc/noc_inject_arbiter.md
# noc_inject_arbiter

Shares one NoC router injection port among NUM_REQ local requesters. Applies round-robin arbitration with wormhole packet locking and per-VC credit-based flow control. Emits one registered flit per cycle into the router's flit input and consumes the router's per-VC credit returns. Sits between user RTL producers and a single NoC node's injection interface.

## Interface
- WIDTH, 128, flit width; field layout shared with the NoC.
- N, 16, NoC node count; destination field is $clog2(N) bits.
- NUM_VC, 2, virtual channels; VC field is $clog2(NUM_VC) bits.
- NUM_REQ, 4, number of requesters (≥2).
- VC_DEPTH, 8, router input buffer depth per VC; initial credit count.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  requester r has a flit on req_flit[r].
- req_flit  in  NUM_REQ×WIDTH  per-requester flit. Head, tail, VC, dest and data fields are set by the requester.
- req_ready  out  NUM_REQ  one-hot grant. The flit is accepted this cycle when valid & ready.
- flit_out  out  WIDTH  flit to the router. The valid bit is at WIDTH-1.
- credits_in  in  NUM_VC  per-VC credit return pulse, one credit per set bit per cycle.
- credit_err  out  1  sticky; a credit returned while that VC's counter equals VC_DEPTH.

## Operation
- Flit fields: valid WIDTH-1, head WIDTH-2, tail WIDTH-3. The VC field is the next $clog2(NUM_VC) bits downward. Dest follows; data is the rest.
- Credit counters: one per VC, width $clog2(VC_DEPTH+1), reset to VC_DEPTH.
  - Send on VC v: counter decrements.
  - credits_in[v] set: counter increments.
  - Both in the same cycle: counter unchanged.
  - Increment at VC_DEPTH saturates and sets credit_err.
- Eligibility of requester r: req_valid[r] and the counter for its flit's VC is >0, using the current-cycle count.
- FSM states:
  - IDLE: round-robin over eligible requesters, searching from last_grant+1.
    - A granted flit with head=1 and tail=0 moves to LOCKED, owner=r.
    - A single-flit packet (head=tail=1) stays in IDLE.
  - LOCKED: only the owner is eligible. Other requesters get no grant even if the owner stalls for credits.
    - A granted flit with tail=1 returns to IDLE.
- last_grant updates on every grant and resets to NUM_REQ-1, so requester 0 wins first.
- At most one req_ready bit is high. It is never high without credit.
- Output flit: req_flit[grant] with the valid bit forced to 1. With no grant, flit_out is all zeros.

## Timing
- req_ready is combinational from req_valid, req_flit VC field, counters, state and last_grant in the same cycle.
- flit_out is registered: a flit granted at cycle t appears on flit_out during cycle t+1. Latency is 1.
- A counter decrement is visible at t+1. A credit returned at cycle t is usable for grants at t+1.
- Back-to-back grants are allowed every cycle while credits last. A VC at VC_DEPTH=8 with no returns allows 8 consecutive flits, then stalls.
- Reset outputs (reset low at an edge):
  - flit_out=0, req_ready=0 during reset.
  - Counters reset to VC_DEPTH, state=IDLE, last_grant=NUM_REQ-1, credit_err=0.
- Reset mid-packet drops the lock. No tail is synthesized.

## Structure
- Package noc_flit_pkg holds:
  - localparams VALID_POS, HEAD_POS, TAIL_POS, VC_POS, DEST_POS, DATA_POS.
  - address widths.
  - functions flit_vc(), flit_is_head(), flit_is_tail().
  - the state enum {IDLE, LOCKED}.
- Sub-module noc_rr_arbiter: a NUM_REQ-wide combinational round-robin pick given a request vector and a pointer. It returns a one-hot grant.
- Top level holds the FSM, owner register, credit counters and output register.

## Test plan
- After reset, requesters 0 and 2 both valid with single-flit packets on VC0. Grants go 0, 2, 0, 2; flit_out valid from the cycle after the first grant.
- Requester 1 sends head/body/tail on VC1 while requester 3 is valid. Requester 3 gets no grant until after requester 1's tail. Requester 3 is granted on the next cycle.
- 10 flits to VC0 with no credits_in. Exactly 8 granted; req_ready stays low until one credits_in[0] pulse, then exactly one more grant.
- A credits_in[0] pulse in the same cycle as a VC0 grant leaves the counter unchanged. A credits_in[1] pulse with VC1 at 8 sets credit_err, which stays set until reset.
- Reset asserted while LOCKED with owner 1 and VC0 at 3 credits. Next cycle: flit_out=0, VC0 back to 8, IDLE, requester 0 wins first.
- Flit from requester 2 with input valid bit 0 and data 0xBAADF00D. flit_out shows valid=1 and data 0xBAADF00D unchanged.
